// File: rtl/datamemory_access_ctrl.sv
// Initiator-side controller for the word-addressed datamemory port.
// Accepts one load/store at a time, handles byte/half lanes, and returns a
// single-cycle response. Sub-word stores use read-modify-write.
module datamemory_access_ctrl #(
   parameter int unsigned SIZE   = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [SIZE-1:0] req_addr,
   input  logic [SIZE-1:0] req_wdata,
   output logic            resp_valid,
   output logic [SIZE-1:0] resp_rdata,
   output logic            resp_err,
   output logic            mem_cs,
   output logic            mem_wr_rd,
   output logic [SIZE-1:0] mem_addr,
   output logic [SIZE-1:0] mem_din,
   input  logic [SIZE-1:0] mem_dout
);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRmwRd,
      StWr,
      StRmwWr,
      StResp
   } state_e;

   localparam logic [1:0] SzByte = 2'b00;
   localparam logic [1:0] SzHalf = 2'b01;
   localparam logic [1:0] SzWord = 2'b10;
   localparam logic [2:0] LastCnt = 3'(RD_LAT);

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            we_q;
   logic [1:0]      size_q;
   logic            uns_q;
   logic            err_q;
   logic [SIZE-1:0] addr_q;
   logic [SIZE-1:0] wdata_q;
   logic [SIZE-1:0] word_q;

   logic            handshake;
   logic            req_bad;
   logic            rd_last;
   logic [7:0]      lane_byte;
   logic [15:0]     lane_half;
   logic [SIZE-1:0] load_data;
   logic [SIZE-1:0] merged;

   assign handshake = (state_q == StIdle) && req_valid;
   assign req_bad   = (req_size == 2'b11) ||
                      ((req_size == SzHalf) && req_addr[0]) ||
                      ((req_size == SzWord) && (req_addr[1:0] != 2'b00));
   // Last cycle of the read window; mem_dout is valid during this cycle.
   assign rd_last   = ((state_q == StRd) || (state_q == StRmwRd)) && (cnt_q == LastCnt);

   // Next-state and read-window counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               cnt_d = 3'd0;
               if (req_bad) begin
                  state_d = StResp;
               end else if (!req_we) begin
                  state_d = StRd;
               end else if (req_size == SzWord) begin
                  state_d = StWr;
               end else begin
                  state_d = StRmwRd;
               end
            end
         end
         StRd, StRmwRd: begin
            if (cnt_q == LastCnt) begin
               state_d = (state_q == StRd) ? StResp : StRmwWr;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StWr, StRmwWr: state_d = StResp;
         StResp:        state_d = StIdle;
         default:       state_d = StIdle;
      endcase
   end

   // State register and counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request capture on handshake; read word capture at end of read window.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
      end else begin
         if (handshake) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            err_q   <= req_bad;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (rd_last) begin
            word_q <= mem_dout;
         end
      end
   end

   // Lane extraction, extension, and store-lane merge (little-endian).
   always_comb begin
      lane_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
      lane_half = word_q[{addr_q[1], 4'b0000} +: 16];
      unique case (size_q)
         SzByte:  load_data = {{(SIZE-8){~uns_q & lane_byte[7]}}, lane_byte};
         SzHalf:  load_data = {{(SIZE-16){~uns_q & lane_half[15]}}, lane_half};
         default: load_data = word_q;
      endcase
      merged = word_q;
      if (size_q == SzByte) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   // Outputs decode only from state and captured registers.
   always_comb begin
      req_ready  = (state_q == StIdle);
      resp_valid = (state_q == StResp);
      resp_err   = resp_valid && err_q;
      resp_rdata = (resp_valid && !err_q && !we_q) ? load_data : '0;
      mem_cs     = (state_q == StRd) || (state_q == StRmwRd) ||
                   (state_q == StWr) || (state_q == StRmwWr);
      mem_wr_rd  = !((state_q == StWr) || (state_q == StRmwWr));
      mem_addr   = mem_cs ? {2'b00, addr_q[SIZE-1:2]} : '0;
      mem_din    = '0;
      if (state_q == StWr) begin
         mem_din = wdata_q;
      end else if (state_q == StRmwWr) begin
         mem_din = merged;
      end
   end

endmodule

// File: tb/tb_datamemory_access_ctrl.sv
// Bench for datamemory_access_ctrl: three instances (read latency 0, 1, 3),
// each with its own datamemory model and a reference model of memory words
// and expected responses, plus directed literal checks.
module tb_datamemory_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int lat, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL lat%0d %s: got %h want %h (cycle %0d)", lat, name, act, exp, cyc);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g
      localparam int unsigned LAT = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;

      logic        reset, clr, active;
      logic        req_valid, req_ready, req_we, req_unsigned;
      logic [1:0]  req_size;
      logic [31:0] req_addr, req_wdata;
      logic        resp_valid, resp_err;
      logic [31:0] resp_rdata;
      logic        mem_cs, mem_wr_rd;
      logic [31:0] mem_addr, mem_din, mem_dout;

      logic [31:0] mem [16];
      logic [31:0] pipe [8];
      logic [31:0] ref_mem [16];

      int          exp_cyc = -1;
      logic [31:0] exp_rdata = '0;
      logic        exp_err = 1'b0;
      logic [31:0] exp_waddr = '0;
      int          last_c0 = 0;
      int          rd_total = 0;
      int          wr_total = 0;
      int          resp_total = 0;
      int          seen_cyc = -1;
      logic [31:0] seen_rdata = '0;
      logic        seen_err = 1'b0;

      datamemory_access_ctrl #(.SIZE(32), .RD_LAT(LAT)) dut (
         .clk          (clk),
         .reset        (reset),
         .req_valid    (req_valid),
         .req_ready    (req_ready),
         .req_we       (req_we),
         .req_size     (req_size),
         .req_unsigned (req_unsigned),
         .req_addr     (req_addr),
         .req_wdata    (req_wdata),
         .resp_valid   (resp_valid),
         .resp_rdata   (resp_rdata),
         .resp_err     (resp_err),
         .mem_cs       (mem_cs),
         .mem_wr_rd    (mem_wr_rd),
         .mem_addr     (mem_addr),
         .mem_din      (mem_din),
         .mem_dout     (mem_dout)
      );

      // Datamemory: write commits at posedge, reads delayed LAT cycles.
      always @(posedge clk) begin
         if (clr) begin
            for (int k = 0; k < 16; k++) mem[k] <= '0;
         end else if (mem_cs && !mem_wr_rd) begin
            mem[mem_addr[3:0]] <= mem_din;
         end
         pipe[0] <= mem[mem_addr[3:0]];
         for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_dout = (LAT == 0) ? mem[mem_addr[3:0]] : pipe[(LAT == 0) ? 0 : LAT - 1];

      // Per-cycle comparison against the expected response schedule.
      always @(negedge clk) begin
         if (active) begin
            check("resp_valid", LAT, 32'(resp_valid), (cyc == exp_cyc) ? 32'd1 : 32'd0);
            if (cyc == exp_cyc) begin
               check("resp_rdata", LAT, resp_rdata, exp_rdata);
               check("resp_err", LAT, 32'(resp_err), 32'(exp_err));
            end else begin
               check("rdata_idle", LAT, resp_rdata, 32'd0);
               check("err_idle", LAT, 32'(resp_err), 32'd0);
            end
            if (req_ready) begin
               check("idle_cs", LAT, 32'(mem_cs), 32'd0);
               check("idle_wr_rd", LAT, 32'(mem_wr_rd), 32'd1);
            end
            if (mem_cs) begin
               check("mem_addr", LAT, mem_addr, exp_waddr);
               if (mem_wr_rd) rd_total <= rd_total + 1;
               else           wr_total <= wr_total + 1;
            end
            if (resp_valid) begin
               resp_total <= resp_total + 1;
               seen_cyc   <= cyc;
               seen_rdata <= resp_rdata;
               seen_err   <= resp_err;
            end
         end
      end

      // One request through the DUT; the model predicts response, latency,
      // access counts and the resulting memory word.
      task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd);
         logic        err;
         int          lat, w, sh, rd0, wr0, exp_rd, exp_wr;
         logic [31:0] old, v, mask;
         err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
         w   = int'(a[5:2]);
         old = ref_mem[w];
         v   = '0;
         if (err)           lat = 1;
         else if (!we)      lat = LAT + 2;
         else if (sz == 2)  lat = 2;
         else               lat = LAT + 3;
         if (!err && !we) begin
            if (sz == 2'd0) begin
               v = (old >> (8 * int'(a[1:0]))) & 32'hff;
               if (!uns && v[7]) v = v | 32'hffffff00;
            end else if (sz == 2'd1) begin
               v = (old >> (16 * int'(a[1]))) & 32'hffff;
               if (!uns && v[15]) v = v | 32'hffff0000;
            end else begin
               v = old;
            end
         end
         exp_rd = (err || (we && sz == 2'd2)) ? 0 : LAT + 1;
         exp_wr = (!err && we) ? 1 : 0;
         check("ready_before", LAT, 32'(req_ready), 32'd1);
         exp_waddr = a >> 2;
         exp_rdata = v;
         exp_err   = err;
         exp_cyc   = cyc + lat;
         last_c0   = cyc;
         rd0 = rd_total;
         wr0 = wr_total;
         req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
         req_addr = a; req_wdata = wd;
         @(posedge clk); #1;
         // Junk on the request bus while busy must be ignored.
         req_valid = 1'b1; req_we = 1'($urandom); req_size = 2'($urandom);
         req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
         repeat (lat - 1) @(posedge clk);
         #1 req_valid = 1'b0;
         @(posedge clk); #1;
         if (!err && we) begin
            if (sz == 2'd2) begin
               ref_mem[w] = wd;
            end else begin
               sh   = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
               mask = ((sz == 2'd0) ? 32'hff : 32'hffff) << sh;
               ref_mem[w] = (old & ~mask) | ((wd << sh) & mask);
            end
         end
         check("rd_cycles", LAT, 32'(rd_total - rd0), 32'(exp_rd));
         check("wr_cycles", LAT, 32'(wr_total - wr0), 32'(exp_wr));
         check("mem_word", LAT, mem[w], ref_mem[w]);
      endtask

      initial begin
         int r0;
         active = 1'b0; clr = 1'b1; reset = 1'b1;
         req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
         req_addr = '0; req_wdata = '0;
         for (int k = 0; k < 16; k++) ref_mem[k] = '0;
         repeat (2) @(posedge clk);
         #1 clr = 1'b0; reset = 1'b0; active = 1'b1;

         // Reset state
         check("rst_ready", LAT, 32'(req_ready), 32'd1);
         check("rst_cs", LAT, 32'(mem_cs), 32'd0);
         check("rst_wr_rd", LAT, 32'(mem_wr_rd), 32'd1);
         check("rst_resp_valid", LAT, 32'(resp_valid), 32'd0);
         check("rst_mem_addr", LAT, mem_addr, 32'd0);
         check("rst_mem_din", LAT, mem_din, 32'd0);

         // Word store then load
         do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h12345678);
         check("sw_lat", LAT, 32'(seen_cyc - last_c0), 32'd2);
         check("sw_word1", LAT, mem[1], 32'h12345678);
         do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
         check("lw_data", LAT, seen_rdata, 32'h12345678);
         check("lw_lat", LAT, 32'(seen_cyc - last_c0), 32'(LAT + 2));

         // Sub-word loads with extension
         do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'hABCDEFFF);
         do_req(1'b0, 2'd0, 1'b0, 32'h1, 32'h0);
         check("lb_1", LAT, seen_rdata, 32'hFFFFFFEF);
         do_req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0);
         check("lbu_3", LAT, seen_rdata, 32'h000000AB);
         do_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
         check("lh_2", LAT, seen_rdata, 32'hFFFFABCD);
         do_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
         check("lhu_0", LAT, seen_rdata, 32'h0000EFFF);

         // Read-modify-write stores
         do_req(1'b1, 2'd2, 1'b0, 32'hC, 32'hAAAA5555);
         do_req(1'b1, 2'd0, 1'b0, 32'hE, 32'h11);
         check("sb_word3", LAT, mem[3], 32'hAA115555);
         check("sb_lat", LAT, 32'(seen_cyc - last_c0), 32'(LAT + 3));
         do_req(1'b1, 2'd1, 1'b0, 32'hC, 32'hBEEF);
         check("sh_word3", LAT, mem[3], 32'hAA11BEEF);

         // Error requests
         do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
         check("lw6_err", LAT, 32'(seen_err), 32'd1);
         check("lw6_lat", LAT, 32'(seen_cyc - last_c0), 32'd1);
         do_req(1'b1, 2'd1, 1'b0, 32'h1, 32'h1234);
         check("sh1_err", LAT, 32'(seen_err), 32'd1);
         do_req(1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
         check("sz3_err", LAT, 32'(seen_err), 32'd1);
         check("sz3_rdata", LAT, seen_rdata, 32'd0);

         // Reset during RMW_RD of SB 0x0: dropped, no write, no response
         exp_cyc = -1; exp_waddr = '0;
         r0 = resp_total;
         req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
         req_addr = 32'h0; req_wdata = 32'h5A;
         @(posedge clk); #1;
         req_valid = 1'b0; reset = 1'b1;
         repeat (2) @(posedge clk);
         #1 reset = 1'b0;
         repeat (LAT + 4) @(posedge clk);
         #1;
         check("rstmid_ready", LAT, 32'(req_ready), 32'd1);
         check("rstmid_word0", LAT, mem[0], 32'hABCDEFFF);
         check("rstmid_noresp", LAT, 32'(resp_total - r0), 32'd0);

         // Randomized traffic
         for (int n = 0; n < 60; n++) begin
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   32'($urandom_range(0, 63)), $urandom);
         end
         active = 1'b0;
         done_cnt++;
      end
   end

   initial begin
      for (int t = 0; t < 20000 && done_cnt < 3; t++) @(posedge clk);
      total++;
      if (done_cnt != 3) begin
         bad++;
         $display("FAIL timeout: got %0d finished instances want 3", done_cnt);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
